// File: rtl/arb_mux2.sv
// Two-input round-robin stream mux with a registered output slot and exported select.
// Define ARB_MUX2_LOCK_EN to hold the grant on one channel until its packet's last beat.
module arb_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    input  logic             i0_last,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    input  logic             i1_last,
    output logic             i1_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel
);

    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             y_valid_q, y_valid_d;
    logic             y_last_q, y_last_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;

    logic             slot_free;
    logic             rr_vld, rr_ch;
    logic             gnt_vld, gnt_ch;
    logic             xfer, xfer_ch, xfer_last;
    logic [WIDTH-1:0] xfer_data;

`ifdef ARB_MUX2_LOCK_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0] state_q, state_d;
`endif

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign slot_free = !y_valid_q || y_ready;

    always_comb begin
        rr_vld = 1'b0;
        rr_ch  = 1'b0;
        if (i0_valid && i1_valid) begin
            rr_vld = 1'b1;
            rr_ch  = prio_q;
        end else if (i0_valid) begin
            rr_vld = 1'b1;
            rr_ch  = 1'b0;
        end else if (i1_valid) begin
            rr_vld = 1'b1;
            rr_ch  = 1'b1;
        end
    end

`ifdef ARB_MUX2_LOCK_EN
    // A locked channel keeps the grant even while it is idle, starving the other side.
    always_comb begin
        gnt_vld = rr_vld;
        gnt_ch  = rr_ch;
        if (state_q == ST_LOCK0) begin
            gnt_vld = i0_valid;
            gnt_ch  = 1'b0;
        end else if (state_q == ST_LOCK1) begin
            gnt_vld = i1_valid;
            gnt_ch  = 1'b1;
        end
    end
`else
    assign gnt_vld = rr_vld;
    assign gnt_ch  = rr_ch;
`endif

    assign i0_ready  = gnt_vld && (gnt_ch == 1'b0) && i0_valid && slot_free;
    assign i1_ready  = gnt_vld && (gnt_ch == 1'b1) && i1_valid && slot_free;

    assign xfer      = i0_ready || i1_ready;
    assign xfer_ch   = i1_ready;
    assign xfer_data = xfer_ch ? i1_data : i0_data;
    assign xfer_last = xfer_ch ? i1_last : i0_last;

    always_comb begin
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        sel_d     = sel_q;
        y_valid_d = y_valid_q;
        if (xfer) begin
            y_data_d  = xfer_data;
            y_last_d  = xfer_last;
            sel_d     = xfer_ch;
            y_valid_d = 1'b1;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

`ifdef ARB_MUX2_LOCK_EN
    // Turns rotate per packet, so priority only moves on a packet's closing beat.
    always_comb begin
        prio_d  = prio_q;
        state_d = state_q;
        if (xfer && xfer_last) begin
            prio_d = ~xfer_ch;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer && !xfer_last) begin
                    state_d = xfer_ch ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0: begin
                if (xfer && !xfer_ch && xfer_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK1: begin
                if (xfer && xfer_ch && xfer_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = ~xfer_ch;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            sel_q     <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_arb_mux2.sv
// Directed, table-driven bench for arb_mux2: one row per clock cycle with hand-computed results.
// Rows for the packet-lock scenario follow ARB_MUX2_LOCK_EN the same way the design does.
module tb_arb_mux2;

    localparam int WIDTH = 8;
    localparam int NVEC  = 23;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] i0_data, i1_data, y_data;
    logic             i0_valid, i0_last, i0_ready;
    logic             i1_valid, i1_last, i1_ready;
    logic             y_valid, y_last, y_ready, sel;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic             prst;
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             l0;
        logic             v1;
        logic [WIDTH-1:0] d1;
        logic             l1;
        logic             yr;
        logic             er0;
        logic             er1;
        logic             eyv;
        logic [WIDTH-1:0] eyd;
        logic             eyl;
        logic             esel;
    } vec_t;

    vec_t vecs [NVEC];

    arb_mux2 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_data  (i0_data),
        .i0_valid (i0_valid),
        .i0_last  (i0_last),
        .i0_ready (i0_ready),
        .i1_data  (i1_data),
        .i1_valid (i1_valid),
        .i1_last  (i1_last),
        .i1_ready (i1_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_last   (y_last),
        .y_ready  (y_ready),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic prst,
                                input logic v0, input logic [WIDTH-1:0] d0, input logic l0,
                                input logic v1, input logic [WIDTH-1:0] d1, input logic l1,
                                input logic yr, input logic er0, input logic er1,
                                input logic eyv, input logic [WIDTH-1:0] eyd,
                                input logic eyl, input logic esel);
        vec_t v;
        v.prst = prst; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.yr = yr;
        v.er0 = er0; v.er1 = er1; v.eyv = eyv; v.eyd = eyd; v.eyl = eyl; v.esel = esel;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //           prst v0 d0    l0 v1 d1    l1 yr  r0 r1  yv yd    yl sel
        // both valid: strict alternation starting with i0
        vecs[0]  = mk(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1, 1, 0, 1, 8'hA0, 1, 0);
        vecs[1]  = mk(0, 1, 8'hA1, 1, 1, 8'hB0, 1, 1, 0, 1, 1, 8'hB0, 1, 1);
        vecs[2]  = mk(0, 1, 8'hA1, 1, 1, 8'hB1, 1, 1, 1, 0, 1, 8'hA1, 1, 0);
        vecs[3]  = mk(0, 1, 8'hA2, 1, 1, 8'hB1, 1, 1, 0, 1, 1, 8'hB1, 1, 1);
        // only i1 valid: 4 beats back to back
        vecs[4]  = mk(0, 0, 8'h00, 0, 1, 8'h11, 0, 1, 0, 1, 1, 8'h11, 0, 1);
        vecs[5]  = mk(0, 0, 8'h00, 0, 1, 8'h12, 0, 1, 0, 1, 1, 8'h12, 0, 1);
        vecs[6]  = mk(0, 0, 8'h00, 0, 1, 8'h13, 0, 1, 0, 1, 1, 8'h13, 0, 1);
        vecs[7]  = mk(0, 0, 8'h00, 0, 1, 8'h14, 1, 1, 0, 1, 1, 8'h14, 1, 1);
        // backpressure for 3 cycles, then release
        vecs[8]  = mk(0, 1, 8'hA2, 1, 1, 8'hB2, 1, 0, 0, 0, 1, 8'h14, 1, 1);
        vecs[9]  = mk(0, 1, 8'hA2, 1, 1, 8'hB2, 1, 0, 0, 0, 1, 8'h14, 1, 1);
        vecs[10] = mk(0, 1, 8'hA2, 1, 1, 8'hB2, 1, 0, 0, 0, 1, 8'h14, 1, 1);
        vecs[11] = mk(0, 1, 8'hA2, 1, 1, 8'hB2, 1, 1, 1, 0, 1, 8'hA2, 1, 0);
        vecs[12] = mk(0, 1, 8'hA3, 1, 1, 8'hB2, 1, 1, 0, 1, 1, 8'hB2, 1, 1);
        // drain keeps data/sel; empty slot accepts even with y_ready low
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hB2, 1, 1);
        vecs[14] = mk(0, 1, 8'hA3, 1, 0, 8'h00, 0, 0, 1, 0, 1, 8'hA3, 1, 0);
        vecs[15] = mk(0, 1, 8'hA4, 1, 1, 8'hB3, 1, 0, 0, 0, 1, 8'hA3, 1, 0);
        // reset pulse with prio=1: afterwards i0 must win
        vecs[16] = mk(1, 1, 8'hA4, 1, 1, 8'hB3, 1, 1, 1, 0, 1, 8'hA4, 1, 0);
        // packet scenario: i1 beat first so i0 holds priority, then 3-beat i0 packet with a gap
        vecs[17] = mk(0, 0, 8'h00, 0, 1, 8'hC0, 1, 1, 0, 1, 1, 8'hC0, 1, 1);
        vecs[18] = mk(0, 1, 8'hD0, 0, 1, 8'hC1, 1, 1, 1, 0, 1, 8'hD0, 0, 0);
`ifdef ARB_MUX2_LOCK_EN
        vecs[19] = mk(0, 0, 8'h00, 0, 1, 8'hC1, 1, 1, 0, 0, 0, 8'hD0, 0, 0);
        vecs[20] = mk(0, 1, 8'hD1, 0, 1, 8'hC1, 1, 1, 1, 0, 1, 8'hD1, 0, 0);
        vecs[21] = mk(0, 1, 8'hD2, 1, 1, 8'hC1, 1, 1, 1, 0, 1, 8'hD2, 1, 0);
        vecs[22] = mk(0, 0, 8'h00, 0, 1, 8'hC1, 1, 1, 0, 1, 1, 8'hC1, 1, 1);
`else
        vecs[19] = mk(0, 0, 8'h00, 0, 1, 8'hC1, 1, 1, 0, 1, 1, 8'hC1, 1, 1);
        vecs[20] = mk(0, 1, 8'hD1, 0, 1, 8'hC2, 1, 1, 1, 0, 1, 8'hD1, 0, 0);
        vecs[21] = mk(0, 1, 8'hD2, 1, 1, 8'hC2, 1, 1, 0, 1, 1, 8'hC2, 1, 1);
        vecs[22] = mk(0, 1, 8'hD2, 1, 1, 8'hC3, 1, 1, 1, 0, 1, 8'hD2, 1, 0);
`endif

        rst      = 1'b1;
        i0_data  = '0; i0_valid = 1'b0; i0_last = 1'b0;
        i1_data  = '0; i1_valid = 1'b0; i1_last = 1'b0;
        y_ready  = 1'b0;

        #2;
        chk("reset y_valid", -1, 32'(y_valid), 32'd0);
        chk("reset y_data",  -1, 32'(y_data),  32'd0);
        chk("reset y_last",  -1, 32'(y_last),  32'd0);
        chk("reset sel",     -1, 32'(sel),     32'd0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-reset y_valid", -1, 32'(y_valid), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].prst) begin
                // Asynchronous reset between edges must clear the slot at once.
                chk("pre-pulse y_valid", i, 32'(y_valid), 32'd1);
                rst = 1'b1;
                #1;
                chk("async rst y_valid", i, 32'(y_valid), 32'd0);
                chk("async rst y_data",  i, 32'(y_data),  32'd0);
                chk("async rst y_last",  i, 32'(y_last),  32'd0);
                chk("async rst sel",     i, 32'(sel),     32'd0);
                rst = 1'b0;
            end
            i0_valid = vecs[i].v0; i0_data = vecs[i].d0; i0_last = vecs[i].l0;
            i1_valid = vecs[i].v1; i1_data = vecs[i].d1; i1_last = vecs[i].l1;
            y_ready  = vecs[i].yr;
            #1;
            chk("i0_ready", i, 32'(i0_ready), 32'(vecs[i].er0));
            chk("i1_ready", i, 32'(i1_ready), 32'(vecs[i].er1));
            @(posedge clk); #1;
            chk("y_valid", i, 32'(y_valid), 32'(vecs[i].eyv));
            chk("y_data",  i, 32'(y_data),  32'(vecs[i].eyd));
            chk("y_last",  i, 32'(y_last),  32'(vecs[i].eyl));
            chk("sel",     i, 32'(sel),     32'(vecs[i].esel));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
